projectile_pool: RTL
====================

# projectile_pool

Multi-slot projectile engine for the fighter game. Replaces the single-bullet projectile block with a pool of independent slots. Each slot is spawned from the shooter's position and advanced once per video frame, and is retired on leaving the screen or touching the target. The block drives `is_proj` to the color mapper and reports hits for health/stage logic.

## Interface
Parameters:
- `N_PROJ`, 4 — number of projectile slots (1–8)
- `STEP`, 4 — pixels moved per frame
- `HALF_SIZE`, 4 — projectile half-width/half-height in pixels
- `COOLDOWN`, 8 — frames between accepted shots
- `X_MIN`, 0 — left screen bound
- `X_MAX`, 639 — right screen bound

Ports:
- `Clk` in 1 — 50 MHz system clock
- `Reset` in 1 — synchronous, active-high
- `frame_clk` in 1 — VGA_VS, level; generated in the `Clk` domain
- `Shoot` in 1 — fire request, level, already synchronized
- `Dir` in 1 — direction latched at spawn: 0 = right (+x), 1 = left (−x)
- `Shooter_X`, `Shooter_Y` in 10 — spawn center
- `Target_X`, `Target_Y` in 10 — target center
- `Target_Size` in 10 — target half-extent for the hit test
- `DrawX`, `DrawY` in 10 — current pixel
- `is_proj` out 1 — pixel lies inside any active projectile
- `hit` out 1 — one-`Clk` pulse on a frame tick where at least one slot hit
- `hit_count` out 8 — saturating total of slot hits
- `active_count` out 4 — number of active slots

## Operation
- Frame tick: `tick = frame_clk & ~frame_clk_q`, where `frame_clk_q` is `frame_clk` registered on `Clk`. `tick` is the rising edge of `frame_clk`.
- Shot latch: a `Shoot` rising edge (registered `Shoot_q`) sets `pending`. `pending` clears on every tick, whether the shot spawned or was dropped. Holding `Shoot` high yields one request.
- Per-slot state: `active`, `x[9:0]`, `y[9:0]`, `dir`.
- On each tick, every slot active before the tick is processed in this order:
  - Bound check. Right-mover with `x + STEP > X_MAX`, or left-mover with `x < X_MIN + STEP`: clear `active` with no move and no hit test. Computed in 11 bits, so no wrap-around.
  - Otherwise move: `x ± STEP`; `y` is unchanged.
  - Hit test on the moved position: `|x' − Target_X| <= Target_Size` AND `|y − Target_Y| <= Target_Size`, using 11-bit signed differences. On hit, clear `active` and count the slot.
- Spawn, same tick:
  - Condition: `pending && cooldown == 0 && any slot free`, where a slot is free before or after this tick's retirements.
  - Action: load the lowest-index free slot with `Shooter_X`, `Shooter_Y`, `Dir`, and set `active`. Load `cooldown = COOLDOWN`.
  - A freshly spawned slot is not moved or hit-tested until the next tick.
  - If no slot is free or `cooldown != 0`, the request is dropped.
- Cooldown: decrements by 1 per tick while non-zero. When a spawn loads it on a tick, the load takes precedence over the decrement.
- `hit_count`: on a tick, add the number of slots that hit this tick, saturating at 255.
- `active_count`: population count of the `active` bits.
- `is_proj`: combinational OR over active slots of `|DrawX − x| < HALF_SIZE && |DrawY − y| < HALF_SIZE`.

## Timing
- Reset values:
  - all `active` = 0; `x`, `y`, `dir` = 0
  - `pending` = 0, `cooldown` = 0, `frame_clk_q` = 0, `Shoot_q` = 0
  - `hit` = 0, `hit_count` = 0, `active_count` = 0
  - `is_proj` = 0
- Reset mid-flight clears everything on the next `Clk` edge, and the pool stays empty until a new shot.
- All slot updates occur on the `Clk` edge where `tick` = 1. `hit` is high for exactly that following cycle.
- `active_count` and `hit_count` are registered; they reflect tick results one `Clk` after the tick edge.
- `is_proj` reflects registered slot state with zero added latency.
- `Shooter_X/Y`, `Dir`, `Target_*` are sampled only on the tick cycle.
- A `Shoot` edge and a tick on the same cycle: the edge is captured and spawns on that tick.

## Test plan
- Reset, single shot:
  - Stimulus: `Shooter`=(260,355), `Dir`=0, one `Shoot` pulse.
  - Response: slot 0 spawns at tick 1. `x` = 264, 268 on the following ticks. `active_count`=1, `is_proj`=1 at DrawX=264, DrawY=355.
- Hit:
  - Stimulus: `Target`=(300,355), `Target_Size`=20; fire right from x=260.
  - Response: first hit when x'=280. `hit` pulses one cycle, `hit_count`=1, `active_count`=0.
- Cooldown and pool full:
  - Stimulus: `COOLDOWN`=8, `N_PROJ`=4; shot edge every frame, target far away.
  - Response: spawns occur only on ticks 1, 10, 19, 28. The 5th shot is dropped while 4 slots are active.
- Screen edge:
  - Stimulus: left-mover spawned at x=6, `STEP`=4.
  - Response: moves to x=2, then retires on the next tick with no wrap to 1022. `hit` stays 0.
- Simultaneous hits:
  - Stimulus: two slots both reach the target box on the same tick.
  - Response: `hit` pulses once, `hit_count` increases by 2. `hit_count` saturates at 255 after further hits.
- Reset mid-flight:
  - Stimulus: assert `Reset` for 1 cycle with 3 slots active.
  - Response: next cycle `active_count`=0, `is_proj`=0, `cooldown`=0. An immediate shot spawns on the next tick.

Source files
------------

// File: rtl/projectile_pool_if.sv
// Purpose: groups the projectile pool's per-frame inputs and its render/score outputs.
// Signals:
//   frame_clk, Shoot, Dir      - frame strobe (level), fire request (level), spawn direction
//   Shooter_X/Y, Target_X/Y    - spawn center and target center
//   Target_Size                - target half-extent for the hit test
//   DrawX/DrawY                - pixel being rendered
//   is_proj, hit, hit_count, active_count - pool outputs
interface projectile_pool_if;
  logic       frame_clk;
  logic       Shoot;
  logic       Dir;
  logic [9:0] Shooter_X;
  logic [9:0] Shooter_Y;
  logic [9:0] Target_X;
  logic [9:0] Target_Y;
  logic [9:0] Target_Size;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_proj;
  logic       hit;
  logic [7:0] hit_count;
  logic [3:0] active_count;

  modport master (
    output frame_clk, Shoot, Dir, Shooter_X, Shooter_Y, Target_X, Target_Y,
           Target_Size, DrawX, DrawY,
    input  is_proj, hit, hit_count, active_count
  );

  modport slave (
    input  frame_clk, Shoot, Dir, Shooter_X, Shooter_Y, Target_X, Target_Y,
           Target_Size, DrawX, DrawY,
    output is_proj, hit, hit_count, active_count
  );
endinterface

// File: rtl/projectile_pool.sv
// Purpose: pool of N_PROJ projectile slots. Slots spawn at the shooter on a frame tick,
// advance STEP pixels per frame, and retire at the screen edge or on touching the target.
// Ports:
//   Clk   - system clock
//   Reset - synchronous, active-high
//   bus   - projectile_pool_if.slave (frame strobe, fire, positions, draw pixel, outputs)
module projectile_pool #(
  parameter int unsigned N_PROJ    = 4,
  parameter int unsigned STEP      = 4,
  parameter int unsigned HALF_SIZE = 4,
  parameter int unsigned COOLDOWN  = 8,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 639
) (
  input  logic             Clk,
  input  logic             Reset,
  projectile_pool_if.slave bus
);

  localparam int unsigned CW     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] XMAX_W = 11'(X_MAX);
  localparam logic [10:0] XLO_W  = 11'(X_MIN + STEP);
  localparam logic [10:0] HALF_W = 11'(HALF_SIZE);

  logic              frame_q, shoot_q;
  logic              pending_q, pending_d;
  logic [CW-1:0]     cool_q, cool_d;
  logic [N_PROJ-1:0] active_q, active_d;
  logic [N_PROJ-1:0] dir_q, dir_d;
  logic [9:0]        x_q [N_PROJ];
  logic [9:0]        x_d [N_PROJ];
  logic [9:0]        y_q [N_PROJ];
  logic [9:0]        y_d [N_PROJ];
  logic              hit_q, hit_d;
  logic [7:0]        hit_count_q, hit_count_d;
  logic [3:0]        active_count_q, active_count_d;

  logic              tick, shoot_edge, spawned;
  logic [10:0]       x_mv;
  logic [3:0]        n_hit;
  logic [8:0]        hit_sum;
  logic              is_proj_c;

  // Magnitude of an 11-bit two's-complement difference.
  function automatic logic [10:0] abs11(input logic [10:0] d);
    return d[10] ? 11'(-d) : d;
  endfunction

  assign tick       = bus.frame_clk & ~frame_q;
  assign shoot_edge = bus.Shoot & ~shoot_q;

  // Per-tick slot update, spawn, cooldown and scoring.
  always_comb begin
    active_d    = active_q;
    dir_d       = dir_q;
    x_d         = x_q;
    y_d         = y_q;
    pending_d   = pending_q;
    cool_d      = cool_q;
    x_mv        = '0;
    n_hit       = '0;
    spawned     = 1'b0;
    hit_sum     = {1'b0, hit_count_q};
    hit_d       = 1'b0;
    hit_count_d = hit_count_q;

    if (tick) begin
      for (int i = 0; i < int'(N_PROJ); i++) begin
        if (active_q[i]) begin
          if (dir_q[i] ? ({1'b0, x_q[i]} < XLO_W)
                       : (({1'b0, x_q[i]} + STEP_W) > XMAX_W)) begin
            active_d[i] = 1'b0;
          end else begin
            x_mv   = dir_q[i] ? ({1'b0, x_q[i]} - STEP_W) : ({1'b0, x_q[i]} + STEP_W);
            x_d[i] = x_mv[9:0];
            if (abs11(x_mv - {1'b0, bus.Target_X}) <= {1'b0, bus.Target_Size} &&
                abs11({1'b0, y_q[i]} - {1'b0, bus.Target_Y}) <= {1'b0, bus.Target_Size}) begin
              active_d[i] = 1'b0;
              n_hit       = n_hit + 4'd1;
            end
          end
        end
      end

      // Slots freed by this tick's retirements are eligible for the spawn.
      if ((pending_q | shoot_edge) && cool_q == '0) begin
        for (int i = 0; i < int'(N_PROJ); i++) begin
          if (!spawned && !active_d[i]) begin
            spawned     = 1'b1;
            active_d[i] = 1'b1;
            dir_d[i]    = bus.Dir;
            x_d[i]      = bus.Shooter_X;
            y_d[i]      = bus.Shooter_Y;
          end
        end
      end

      if (spawned)             cool_d = CW'(COOLDOWN);
      else if (cool_q != '0)   cool_d = cool_q - CW'(1);

      pending_d   = 1'b0;
      hit_d       = (n_hit != 4'd0);
      hit_sum     = {1'b0, hit_count_q} + 9'(n_hit);
      hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];
    end else if (shoot_edge) begin
      pending_d = 1'b1;
    end

    active_count_d = '0;
    for (int i = 0; i < int'(N_PROJ); i++) begin
      active_count_d = active_count_d + 4'(active_d[i]);
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q        <= 1'b0;
      shoot_q        <= 1'b0;
      pending_q      <= 1'b0;
      cool_q         <= '0;
      active_q       <= '0;
      dir_q          <= '0;
      x_q            <= '{default: '0};
      y_q            <= '{default: '0};
      hit_q          <= 1'b0;
      hit_count_q    <= '0;
      active_count_q <= '0;
    end else begin
      frame_q        <= bus.frame_clk;
      shoot_q        <= bus.Shoot;
      pending_q      <= pending_d;
      cool_q         <= cool_d;
      active_q       <= active_d;
      dir_q          <= dir_d;
      x_q            <= x_d;
      y_q            <= y_d;
      hit_q          <= hit_d;
      hit_count_q    <= hit_count_d;
      active_count_q <= active_count_d;
    end
  end

  // Pixel coverage test against every active slot.
  always_comb begin
    is_proj_c = 1'b0;
    for (int i = 0; i < int'(N_PROJ); i++) begin
      if (active_q[i] &&
          abs11({1'b0, bus.DrawX} - {1'b0, x_q[i]}) < HALF_W &&
          abs11({1'b0, bus.DrawY} - {1'b0, y_q[i]}) < HALF_W) begin
        is_proj_c = 1'b1;
      end
    end
  end

  assign bus.is_proj      = is_proj_c;
  assign bus.hit          = hit_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.active_count = active_count_q;

endmodule
